// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: holds the fetch PC, drives the instruction SRAM, buffers stalled redirects.
// Latency: a redirect accepted at an edge shows on pc the next cycle; SRAM read data returns one cycle after inst_sram_en.
// Backpressure: stall[0] freezes pc and gates inst_sram_en; a branch arriving while stalled is parked until the stall clears.
module if_pc_gen #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter logic [63:0] FETCH_BASE  = 64'h0000_0000_8000_0000,
    parameter logic [63:0] FETCH_LIMIT = 64'h0000_0000_87FF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    input  logic        br_e,
    input  logic [63:0] br_addr,
    output logic        pc_valid,
    output logic [63:0] pc,
    output logic [31:0] csr_vec_h,
    output logic        inst_sram_en,
    output logic [63:0] inst_sram_addr
);

    typedef struct packed {
        logic [63:0] pc;
        logic        pc_valid;
        logic        pend_v;
        logic [63:0] pend_pc;
    } fetch_state_t;

    fetch_state_t cur;
    fetch_state_t nxt;

    logic if_hold;
    logic misaligned;
    logic out_of_range;
    logic unused_stall;

    assign if_hold      = stall[0];
    assign unused_stall = ^stall[5:1];

    // Redirect priority: flush, then parking during a stall, then live branch over parked one.
    always_comb begin
        nxt = cur;
        if (flush) begin
            nxt.pc       = flush_pc;
            nxt.pc_valid = 1'b1;
            nxt.pend_v   = 1'b0;
        end else if (if_hold) begin
            if (br_e) begin
                nxt.pend_v  = 1'b1;
                nxt.pend_pc = br_addr;
            end
        end else if (br_e) begin
            nxt.pc       = br_addr;
            nxt.pc_valid = 1'b1;
            nxt.pend_v   = 1'b0;
        end else if (cur.pend_v) begin
            nxt.pc       = cur.pend_pc;
            nxt.pc_valid = 1'b1;
            nxt.pend_v   = 1'b0;
        end else if (!cur.pc_valid) begin
            nxt.pc_valid = 1'b1;
        end else begin
            nxt.pc = cur.pc + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur.pc       <= RESET_PC;
            cur.pc_valid <= 1'b0;
            cur.pend_v   <= 1'b0;
            cur.pend_pc  <= 64'd0;
        end else begin
            cur <= nxt;
        end
    end

    // Bad targets are still fetched; the fault travels to decode as flags only.
    assign misaligned   = cur.pc_valid & (cur.pc[1:0] != 2'b00);
    assign out_of_range = cur.pc_valid & ((cur.pc < FETCH_BASE) | (cur.pc > FETCH_LIMIT));

    assign pc             = cur.pc;
    assign pc_valid       = cur.pc_valid;
    assign csr_vec_h      = {30'd0, out_of_range, misaligned};
    assign inst_sram_en   = cur.pc_valid & ~if_hold;
    assign inst_sram_addr = {cur.pc[63:3], 3'b000};

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboarded bench for if_pc_gen: driver pushes expected outputs from a rule-level model, monitor pops and compares.
module tb_if_pc_gen;

    localparam logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] FETCH_BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] FETCH_LIMIT = 64'h0000_0000_87FF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] flush_pc;
    logic        br_e;
    logic [63:0] br_addr;
    logic        pc_valid;
    logic [63:0] pc;
    logic [31:0] csr_vec_h;
    logic        inst_sram_en;
    logic [63:0] inst_sram_addr;

    if_pc_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .br_e           (br_e),
        .br_addr        (br_addr),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .csr_vec_h      (csr_vec_h),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        vld;
        logic [31:0] csr;
        logic        en;
        logic [63:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the architectural view (fetch PC, whether it is live, one parked redirect).
    logic [63:0] m_pc;
    logic        m_vld;
    logic        m_pend;
    logic [63:0] m_pend_pc;
    bit          m_known = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_csr(input logic [63:0] p, input logic v);
        logic [31:0] c;
        c = 32'd0;
        if (v && (p % 4 != 0)) c = c | 32'h1;
        if (v && (p < FETCH_BASE || p > FETCH_LIMIT)) c = c | 32'h2;
        return c;
    endfunction

    // Drive one cycle's inputs after a posedge, record what the DUT must show now, then advance the model.
    task automatic step(input bit r, input bit st, input bit fl, input logic [63:0] fpc,
                        input bit be, input logic [63:0] ba);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n    = r;
        stall    = {5'b10101, st};
        flush    = fl;
        flush_pc = fpc;
        br_e     = be;
        br_addr  = ba;
        if (m_known) begin
            e.pc   = m_pc;
            e.vld  = m_vld;
            e.csr  = exp_csr(m_pc, m_vld);
            e.en   = m_vld && !st;
            e.addr = m_pc & ~64'd7;
            sb.push_back(e);
        end
        if (!r) begin
            m_pc = RESET_PC; m_vld = 0; m_pend = 0; m_pend_pc = 0; m_known = 1;
        end else if (fl) begin
            m_pc = fpc; m_vld = 1; m_pend = 0;
        end else if (st) begin
            if (be) begin m_pend = 1; m_pend_pc = ba; end
        end else if (be) begin
            m_pc = ba; m_vld = 1; m_pend = 0;
        end else if (m_pend) begin
            m_pc = m_pend_pc; m_vld = 1; m_pend = 0;
        end else if (!m_vld) begin
            m_vld = 1;
        end else begin
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic go(input bit st, input bit be, input logic [63:0] ba);
        step(1, st, 0, 64'd0, be, ba);
    endtask

    task automatic direct(input string name, input logic [63:0] req_pc, input logic req_vld,
                          input logic [31:0] req_csr);
        #1;
        chk({name, "_pc"}, pc, req_pc);
        chk({name, "_vld"}, {63'd0, pc_valid}, {63'd0, req_vld});
        chk({name, "_csr"}, {32'd0, csr_vec_h}, {32'd0, req_csr});
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return FETCH_BASE + (64'($urandom_range(0, 16'h3FFF)) << 2);
            1: return FETCH_BASE + (64'($urandom_range(0, 16'h3FFF)) << 2) + 64'($urandom_range(1, 3));
            2: return {$urandom, $urandom} & ~64'd3;
            default: return FETCH_LIMIT - 64'd3 - (64'($urandom_range(0, 3)) << 2);
        endcase
    endfunction

    // Monitor: compares whatever the driver queued, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_pc_valid", {63'd0, pc_valid}, {63'd0, e.vld});
                chk("sb_csr_vec_h", {32'd0, csr_vec_h}, {32'd0, e.csr});
                chk("sb_sram_en", {63'd0, inst_sram_en}, {63'd0, e.en});
                chk("sb_sram_addr", inst_sram_addr, e.addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 0; stall = '0; flush = 0; flush_pc = '0; br_e = 0; br_addr = '0;

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        go(0, 0, 0); direct("rst_cyc0", 64'h8000_0000, 0, 0);
        chk("rst_sram_en", {63'd0, inst_sram_en}, 64'd0);
        go(0, 0, 0); direct("rst_cyc1", 64'h8000_0000, 1, 0);
        go(0, 0, 0); direct("rst_cyc2", 64'h8000_0004, 1, 0);
        go(0, 0, 0); direct("rst_cyc3", 64'h8000_0008, 1, 0);
        go(0, 0, 0);
        go(0, 1, 64'h8000_0100); direct("br_at", 64'h8000_0010, 1, 0);
        go(0, 0, 0); direct("br_tgt", 64'h8000_0100, 1, 0);
        go(0, 0, 0); direct("br_tgt4", 64'h8000_0104, 1, 0);

        go(0, 1, 64'h8000_0020);
        go(1, 1, 64'h8000_0200); direct("stall1", 64'h8000_0020, 1, 0);
        chk("stall_sram_en", {63'd0, inst_sram_en}, 64'd0);
        go(1, 1, 64'h8000_0300); direct("stall2", 64'h8000_0020, 1, 0);
        go(1, 0, 0); direct("stall3", 64'h8000_0020, 1, 0);
        go(0, 0, 0); direct("release", 64'h8000_0020, 1, 0);
        go(0, 0, 0); direct("pend_taken", 64'h8000_0300, 1, 0);

        go(1, 1, 64'h8000_0500);
        step(1, 1, 1, 64'h8000_1000, 1, 64'h8000_0600);
        go(0, 0, 0); direct("flush_tgt", 64'h8000_1000, 1, 0);
        go(0, 0, 0); direct("flush_next", 64'h8000_1004, 1, 0);

        go(0, 1, 64'h8000_0102);
        go(0, 1, 64'h0000_1000); direct("misalign", 64'h8000_0102, 1, 32'h1);
        go(0, 1, 64'hFFFF_FFFF_FFFF_FFF8); direct("range", 64'h0000_1000, 1, 32'h2);
        go(0, 0, 0);
        go(0, 0, 0); direct("top", 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h2);
        go(0, 0, 0); direct("wrap", 64'h0, 1, 32'h2);

        go(1, 1, 64'h8000_0700);
        step(0, 1, 1, 64'h8000_0900, 1, 64'h8000_0800);
        step(1, 0, 0, 0, 0, 0); direct("rst_mid", 64'h8000_0000, 0, 0);
        go(0, 0, 0); direct("rst_mid1", 64'h8000_0000, 1, 0);
        go(0, 0, 0); direct("rst_mid2", 64'h8000_0004, 1, 0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 5), rand_addr(),
                 ($urandom_range(0, 99) < 20), rand_addr());
        end

        repeat (3) @(posedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
